// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : fifo_drain
// Brief    : Drains a shift-register delay fifo into a local row buffer that
//            can be read back by index. Optional macro FIFO_DRAIN_RECIRC_EN
//            feeds each drained word back into the fifo (non-destructive read).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_drain #(
    parameter int DEPTH = 8,
    parameter int BITS  = 8,
    localparam int IW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] fifo_q,
    output logic            fifo_en,
    output logic [BITS-1:0] fifo_d,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   count,
    input  logic [IW-1:0]   rd_idx,
    output logic [BITS-1:0] rd_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] c_DEPTH = IW'(DEPTH);
    localparam logic [IW-1:0] c_LAST  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] c_ONE   = IW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [BITS-1:0] r_buf [DEPTH];
    logic [IW-1:0]   r_count;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_rd_idx;

    assign w_wr_idx = r_count[AW-1:0];
    assign w_rd_idx = rd_idx[AW-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_DRAIN;
            S_DRAIN: if (r_count == c_LAST) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Each DRAIN edge captures the pre-shift oldest word, so buf[0] is the oldest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_count <= '0;
            end else if (r_state == S_DRAIN) begin
                r_buf[w_wr_idx] <= fifo_q;
                r_count         <= r_count + c_ONE;
            end
        end
    end

    assign busy    = (r_state == S_DRAIN);
    assign fifo_en = (r_state == S_DRAIN);
    assign done    = (r_state == S_DONE);
    assign count   = r_count;
    assign rd_data = (rd_idx < c_DEPTH) ? r_buf[w_rd_idx] : '0;

`ifdef FIFO_DRAIN_RECIRC_EN
    assign fifo_d = (r_state == S_DRAIN) ? fifo_q : '0;
`else
    assign fifo_d = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_drain
// Brief    : Self-checking bench for fifo_drain with a behavioural shift fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;

    localparam int DEPTH = 8;
    localparam int BITS  = 8;
    localparam int IW    = $clog2(DEPTH) + 1;

`ifdef FIFO_DRAIN_RECIRC_EN
    localparam bit RECIRC = 1'b1;
`else
    localparam bit RECIRC = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [BITS-1:0] fifo_q;
    logic            fifo_en;
    logic [BITS-1:0] fifo_d;
    logic            busy;
    logic            done;
    logic [IW-1:0]   count;
    logic [IW-1:0]   rd_idx = '0;
    logic [BITS-1:0] rd_data;

    logic            tb_push = 1'b0;
    logic [BITS-1:0] tb_d = '0;
    logic [BITS-1:0] m [DEPTH] = '{default: '0};

    logic [BITS-1:0] q_fifo [$];
    logic [BITS-1:0] q_exp  [$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_drain #(.DEPTH(DEPTH), .BITS(BITS)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .fifo_q  (fifo_q),
        .fifo_en (fifo_en),
        .fifo_d  (fifo_d),
        .busy    (busy),
        .done    (done),
        .count   (count),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    // Attached shift-register fifo: m[0] is the oldest word, new words enter at the tail.
    assign fifo_q = m[0];
    always @(posedge clk) begin
        if (fifo_en || tb_push) begin
            for (int i = 0; i < DEPTH - 1; i++) m[i] <= m[i+1];
            m[DEPTH-1] <= tb_push ? tb_d : fifo_d;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [BITS-1:0] v);
        tb_push = 1'b1;
        tb_d    = v;
        step();
        tb_push = 1'b0;
        void'(q_fifo.pop_front());
        q_fifo.push_back(v);
    endtask

    // Called when a start is accepted: records what the run must capture and
    // what the fifo holds afterwards.
    task automatic load_exp(input bit keep);
        for (int i = 0; i < DEPTH; i++) begin
            if (keep) q_exp.push_back(q_fifo[i]);
            if (!RECIRC) q_fifo[i] = '0;
        end
    endtask

    task automatic readback(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_idx = IW'(i);
            #1;
            check($sformatf("%s rd[%0d]", tag, i), rd_data, q_exp.pop_front());
        end
    endtask

    // Starts in the first DRAIN cycle; ends in the cycle after the done pulse.
    task automatic drain_cycles(input string tag, input bit inject);
        for (int c = 1; c <= DEPTH + 1; c++) begin
            if (inject) start = (c == 3 || c == 5);
            check($sformatf("%s en c%0d", tag, c), fifo_en, (c <= DEPTH));
            check($sformatf("%s busy c%0d", tag, c), busy, (c <= DEPTH));
            check($sformatf("%s done c%0d", tag, c), done, (c == DEPTH + 1));
            check($sformatf("%s cnt c%0d", tag, c), count, c - 1);
            check($sformatf("%s d c%0d", tag, c), fifo_d,
                  (RECIRC && c <= DEPTH) ? fifo_q : '0);
            step();
        end
        if (inject) start = 1'b0;
    endtask

    task automatic run(input string tag, input bit inject);
        load_exp(1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        drain_cycles(tag, inject);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("%s post en", tag), fifo_en, 0);
            check($sformatf("%s post done", tag), done, 0);
            check($sformatf("%s post cnt", tag), count, DEPTH);
            step();
        end
        readback(tag);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) q_fifo.push_back('0);

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst cnt", count, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst en", fifo_en, 0);
        check("rst d", fifo_d, 0);
        for (int i = 0; i < DEPTH; i++) q_exp.push_back('0);
        readback("rst");

        // Basic drain and a second run (recirc-dependent contents)
        for (int k = 1; k <= DEPTH; k++) push(BITS'(k));
        run("run1", 1'b0);
        run("run2", 1'b0);

        // Start pulses during DRAIN are ignored
        for (int k = 1; k <= DEPTH; k++) push(BITS'(k + 16));
        run("inj", 1'b1);

        // Reset mid-run
        for (int k = 1; k <= DEPTH; k++) push(BITS'(k + 32));
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort en", fifo_en, 0);
        check("abort busy", busy, 0);
        check("abort cnt", count, 0);
        for (int c = 0; c < DEPTH + 2; c++) begin
            check("abort done", done, 0);
            step();
        end
        for (int i = 0; i < DEPTH; i++) q_exp.push_back('0);
        readback("abort");

        // Refill fully, so the partially shifted contents no longer matter
        for (int k = 1; k <= DEPTH; k++) push(BITS'(k + 48));
        run("run6", 1'b0);
        rd_idx = IW'(8);
        #1;
        check("rd idx8", rd_data, 0);
        rd_idx = IW'(15);
        #1;
        check("rd idx15", rd_data, 0);

        // start held high: back-to-back runs with one IDLE cycle between
        for (int k = 1; k <= DEPTH; k++) push(BITS'(k + 64));
        start = 1'b1;
        load_exp(1'b0);
        step();
        drain_cycles("b2bA", 1'b0);
        check("b2b idle en", fifo_en, 0);
        check("b2b idle done", done, 0);
        check("b2b idle busy", busy, 0);
        load_exp(1'b1);
        step();
        start = 1'b0;
        drain_cycles("b2bB", 1'b0);
        check("b2b end en", fifo_en, 0);
        readback("b2bB");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
